// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and FSM state type for the register-write arbiter.
package reg_write_arbiter_pkg;

    localparam int unsigned ANCHO_DEF    = 8;
    localparam int unsigned HOLD_MAX_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Round-robin picker: first set req bit scanning ptr+1, ptr+2, ... mod N_REQ.
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    int unsigned idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter driving the enable/data of one shared D register.
// Optional hold timeout in WAIT enabled with macro ARB_HOLD_TIMEOUT_EN.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned ANCHO    = ANCHO_DEF,
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*ANCHO-1:0] din,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic                   reg_en,
    output logic [ANCHO-1:0]       reg_data,
    output logic                   timeout_err
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             reg_en_q, reg_en_d;
    logic [ANCHO-1:0] reg_data_q, reg_data_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] winner_q, winner_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0] pick;
    logic             any_req;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_hold_max;
    assign unused_hold_max = 32'(HOLD_MAX);
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (pick),
        .any_req (any_req)
    );

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            reg_en_q   <= 1'b0;
            reg_data_q <= '0;
            ptr_q      <= IDX_W'(N_REQ - 1);
            winner_q   <= '0;
            timeout_q  <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            reg_en_q   <= reg_en_d;
            reg_data_q <= reg_data_d;
            ptr_q      <= ptr_d;
            winner_q   <= winner_d;
            timeout_q  <= timeout_d;
`ifdef ARB_HOLD_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Next-state logic; ack/reg_en are set on the IDLE->LOAD edge so they are high in LOAD.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ack_d      = '0;
        reg_en_d   = 1'b0;
        reg_data_d = reg_data_q;
        ptr_d      = ptr_q;
        winner_d   = winner_q;
        timeout_d  = timeout_q;
`ifdef ARB_HOLD_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (any_req) begin
                    winner_d   = pick;
                    grant_d    = N_REQ'(1) << pick;
                    ack_d      = N_REQ'(1) << pick;
                    reg_en_d   = 1'b1;
                    reg_data_d = din[32'(pick)*ANCHO +: ANCHO];
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
`ifdef ARB_HOLD_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (!req[winner_q]) begin
                    ptr_d   = winner_q;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
`ifdef ARB_HOLD_TIMEOUT_EN
                else if (cnt_q >= CNT_W'(HOLD_MAX - 1)) begin
                    ptr_d     = winner_q;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant       = grant_q;
    assign ack         = ack_q;
    assign reg_en      = reg_en_q;
    assign reg_data    = reg_data_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a model of the shared D register.
// Build with ARB_HOLD_TIMEOUT_EN defined to exercise the hold timeout path.
module tb_reg_write_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned ANCHO = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*ANCHO-1:0] din;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       ack;
    logic                   reg_en;
    logic [ANCHO-1:0]       reg_data;
    logic                   timeout_err;

    logic [ANCHO-1:0] shreg = '0;
    int en_cnt  = 0;
    int ack_cnt = 0;
    int exp_en  = 0;
    int checks  = 0;
    int errors  = 0;

    reg_write_arbiter #(
        .N_REQ    (N_REQ),
        .ANCHO    (ANCHO),
        .HOLD_MAX (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .din         (din),
        .grant       (grant),
        .ack         (ack),
        .reg_en      (reg_en),
        .reg_data    (reg_data),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Shared enable-loaded register plus pulse counters.
    always @(posedge clk) begin
        if (reg_en === 1'b1) begin
            shreg  <= reg_data;
            en_cnt <= en_cnt + 1;
        end
        if (|ack === 1'b1) ack_cnt <= ack_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [ANCHO-1:0] d_w;

    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        din   = {8'h44, 8'h33, 8'h22, 8'h11};
        tick;
        tick;
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_ack", 32'(ack), 32'h0);
        check_eq("rst_en", 32'(reg_en), 32'h0);
        check_eq("rst_data", 32'(reg_data), 32'h0);
        check_eq("rst_tmo", 32'(timeout_err), 32'h0);

        // 1: first grant goes to requester 0
        reset = 1'b0;
        tick;
        exp_en++;
        check_eq("t1_grant", 32'(grant), 32'h1);
        check_eq("t1_ack", 32'(ack), 32'h1);
        check_eq("t1_en", 32'(reg_en), 32'h1);
        check_eq("t1_data", 32'(reg_data), 32'h11);
        tick;
        check_eq("t1_en_off", 32'(reg_en), 32'h0);
        check_eq("t1_shreg", 32'(shreg), 32'h11);
        req[0] = 1'b0;
        tick;
        check_eq("t1_rel", 32'(grant), 32'h0);
        req[0] = 1'b1;

        // 2: rotation 1,2,3,0 with release one cycle after ack
        for (int k = 0; k < 4; k++) begin
            int w;
            w = (k + 1) % 4;
            d_w = din[w*ANCHO +: ANCHO];
            tick;
            exp_en++;
            check_eq($sformatf("t2_grant%0d", w), 32'(grant), 32'(1) << w);
            check_eq($sformatf("t2_en%0d", w), 32'(reg_en), 32'h1);
            check_eq($sformatf("t2_data%0d", w), 32'(reg_data), 32'(d_w));
            tick;
            check_eq($sformatf("t2_wait%0d", w), 32'(reg_en), 32'h0);
            check_eq($sformatf("t2_shreg%0d", w), 32'(shreg), 32'(d_w));
            req[w] = 1'b0;
            tick;
            check_eq($sformatf("t2_rel%0d", w), 32'(grant), 32'h0);
            req[w] = 1'b1;
        end

        // 3: WAIT ignores other reqs and late din changes
        req = 4'b0011;
        tick;
        exp_en++;
        check_eq("t3_grant", 32'(grant), 32'h2);
        tick;
        req[2] = 1'b1;
        din[1*ANCHO +: ANCHO] = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            tick;
            check_eq("t3_no_en", 32'(reg_en), 32'h0);
            check_eq("t3_hold", 32'(grant), 32'h2);
        end
        check_eq("t3_shreg", 32'(shreg), 32'h22);
        req = 4'b0101;
        tick;
        check_eq("t3_idle", 32'(grant), 32'h0);
        tick;
        exp_en++;
        check_eq("t3_next", 32'(grant), 32'h4);
        check_eq("t3_ndata", 32'(reg_data), 32'h33);

        // 4: reset during LOAD aborts
        reset = 1'b1;
        tick;
        check_eq("t4_grant", 32'(grant), 32'h0);
        check_eq("t4_ack", 32'(ack), 32'h0);
        check_eq("t4_en", 32'(reg_en), 32'h0);
        reset = 1'b0;
        req   = 4'b1000;
        tick;
        exp_en++;
        check_eq("t4_g3", 32'(grant), 32'h8);
        check_eq("t4_d3", 32'(reg_data), 32'h44);
        tick;
        req = 4'b0000;
        tick;

        // 5: requester 2 holds req indefinitely while 0 waits
        req = 4'b0100;
        tick;
        exp_en++;
        check_eq("t5_g2", 32'(grant), 32'h4);
        req = 4'b0101;
        tick;
`ifdef ARB_HOLD_TIMEOUT_EN
        tick;
        tick;
        tick;
        check_eq("t5_held", 32'(grant), 32'h4);
        check_eq("t5_tmo0", 32'(timeout_err), 32'h0);
        tick;
        check_eq("t5_forced", 32'(grant), 32'h0);
        check_eq("t5_tmo1", 32'(timeout_err), 32'h1);
        tick;
        exp_en++;
        check_eq("t5_g0", 32'(grant), 32'h1);
        check_eq("t5_d0", 32'(reg_data), 32'h11);
`else
        for (int k = 0; k < 20; k++) tick;
        check_eq("t5_held", 32'(grant), 32'h4);
        check_eq("t5_tmo", 32'(timeout_err), 32'h0);
        check_eq("t5_no_en", 32'(reg_en), 32'h0);
`endif
        req = 4'b0000;
        tick;
        tick;
        tick;
        check_eq("t5_idle", 32'(grant), 32'h0);

        // 6: single requester toggling, 5A then C3
        din[1*ANCHO +: ANCHO] = 8'h5A;
        req = 4'b0010;
        tick;
        exp_en++;
        check_eq("t6_g1a", 32'(grant), 32'h2);
        tick;
        check_eq("t6_5a", 32'(shreg), 32'h5A);
        req = 4'b0000;
        tick;
        din[1*ANCHO +: ANCHO] = 8'hC3;
        req = 4'b0010;
        tick;
        exp_en++;
        check_eq("t6_g1b", 32'(grant), 32'h2);
        tick;
        check_eq("t6_c3", 32'(shreg), 32'hC3);
        req = 4'b0000;
        tick;
        check_eq("t6_idle", 32'(grant), 32'h0);

        check_eq("en_count", 32'(en_cnt), 32'(exp_en));
        check_eq("ack_count", 32'(ack_cnt), 32'(exp_en));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
